// File: rtl/button_pio_in.sv
// Avalon-MM input PIO: synchronises and debounces pushbuttons/switches, and exposes
// the debounced level, an IRQ mask and a sticky edge-capture register with a level IRQ.
module button_pio_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } addr_e;

  logic [WIDTH-1:0]      sync1_q, sync_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      stable_q, stable_d;
  logic [WIDTH-1:0]      stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0][1:0] agree_q, agree_d;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [WIDTH-1:0]      cap_q, cap_d;

  logic             tick;
  logic             wr_en;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;

  assign tick  = (cnt_q == TICK_LAST);
  assign wr_en = chipselect && !write_n;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    stable_d     = stable_q;
    agree_d      = agree_q;
    stable_dly_d = stable_q;

    // Three consecutive disagreeing ticks with no agreeing cycle between them commit the level.
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_q[i] == stable_q[i]) begin
        agree_d[i] = 2'd0;
      end else if (tick) begin
        if (agree_q[i] == 2'd2) begin
          stable_d[i] = sync_q[i];
          agree_d[i]  = 2'd0;
        end else begin
          agree_d[i] = agree_q[i] + 2'd1;
        end
      end
    end

    if (EDGE_TYPE == 0) begin
      edge_det = stable_q & ~stable_dly_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~stable_q & stable_dly_q;
    end else begin
      edge_det = stable_q ^ stable_dly_q;
    end

    clr_bits = (wr_en && address == ADDR_EDGE) ? writedata : '0;
    // A fresh edge beats a simultaneous write-1-to-clear on the same bit.
    cap_d    = (cap_q & ~clr_bits) | edge_det;
    mask_d   = (wr_en && address == ADDR_MASK) ? writedata : mask_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync_q       <= '0;
      cnt_q        <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      agree_q      <= '0;
      mask_q       <= '0;
      cap_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q      <= in_port;
      sync_q       <= sync1_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      agree_q      <= agree_d;
      mask_q       <= mask_d;
      cap_q        <= cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = stable_q;
      ADDR_RSVD: readdata = '0;
      ADDR_MASK: readdata = mask_q;
      ADDR_EDGE: readdata = cap_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(cap_q & mask_q);

endmodule
